// File: rtl/bp_cce_pkg.sv
// Shared CCE definitions: the coherence-state encoding used by the directory
// read-out stage and the flag generator, plus the directory-entry layout.
`ifndef BP_CCE_PKG_SV
`define BP_CCE_PKG_SV

// Directory entry {tag, coh}. Tag width is a per-instance parameter, so the
// layout is a macro that each user expands into a local typedef.
`define BP_CCE_DIR_ENTRY_S(tag_w) \
  struct packed { logic [(tag_w)-1:0] tag; bp_cce_pkg::bp_coh_states_e coh; }

package bp_cce_pkg;

  localparam int bp_cce_coh_bits = 3;

  // Bit positions inside a coherence state.
  localparam int coh_shared_bit = 0;
  localparam int coh_owned_bit  = 1;
  localparam int coh_dirty_bit  = 2;

  // Invalid must stay all-zero: the row compare treats zero as "no copy".
  typedef enum logic [bp_cce_coh_bits-1:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

  // ceil(log2(n)), but never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/bp_cce_dir_row_cmp.sv
// Combinational compare of one directory row against a request tag. Reports
// whether any valid way holds the tag, and the lowest such way and its state.
module bp_cce_dir_row_cmp
  import bp_cce_pkg::*;
#(
  parameter  int lce_assoc_p     = 8,
  parameter  int tag_width_p     = 8,
  localparam int lg_lce_assoc_lp = safe_clog2(lce_assoc_p),
  localparam int entry_width_lp  = tag_width_p + bp_cce_coh_bits
) (
  input  logic [lce_assoc_p*entry_width_lp-1:0] row_i,
  input  logic [tag_width_p-1:0]                tag_i,
  output logic                                  hit_o,
  output logic [lg_lce_assoc_lp-1:0]            way_o,
  output logic [bp_cce_coh_bits-1:0]            coh_o
);

  typedef `BP_CCE_DIR_ENTRY_S(tag_width_p) dir_entry_s;

  dir_entry_s [lce_assoc_p-1:0] entries;
  logic       [lce_assoc_p-1:0] match;

  assign entries = row_i;

  // Per-way match: same tag and a copy that is not invalid.
  always_comb begin
    for (int w = 0; w < lce_assoc_p; w++) begin
      match[w] = (entries[w].tag == tag_i) && (entries[w].coh != e_COH_I);
    end
  end

  // Lowest-index priority encode: scan downward so the lowest match is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a row with
    // no match would leave way_o/coh_o unassigned and infer latches.
    hit_o = |match;
    way_o = '0;
    coh_o = '0;
    for (int w = lce_assoc_p - 1; w >= 0; w--) begin
      if (match[w]) begin
        way_o = lg_lce_assoc_lp'(w);
        coh_o = entries[w].coh;
      end
    end
  end

endmodule

// File: rtl/bp_cce_dir_rd.sv
// Directory read-out stage: walks one LCE row per cycle for a way-group,
// compares each row against the request tag and builds per-LCE hit, way and
// state vectors, held valid until consumed by a new read or invalidated.
module bp_cce_dir_rd
  import bp_cce_pkg::*;
#(
  parameter  int num_lce_p            = 4,
  parameter  int lce_assoc_p          = 8,
  parameter  int tag_width_p          = 8,
  parameter  int num_way_groups_p     = 4,
  localparam int lg_num_lce_lp        = safe_clog2(num_lce_p),
  localparam int lg_lce_assoc_lp      = safe_clog2(lce_assoc_p),
  localparam int lg_num_way_groups_lp = safe_clog2(num_way_groups_p),
  localparam int entry_width_lp       = tag_width_p + bp_cce_coh_bits
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          rd_v_i,
  output logic                                          rd_ready_o,
  input  logic [lg_num_way_groups_lp-1:0]               way_group_i,
  input  logic [tag_width_p-1:0]                        tag_i,
  input  logic                                          inv_i,
  output logic                                          ram_v_o,
  output logic [lg_num_way_groups_lp+lg_num_lce_lp-1:0] ram_addr_o,
  input  logic [lce_assoc_p*entry_width_lp-1:0]         ram_data_i,
  output logic                                          sharers_v_o,
  output logic [num_lce_p-1:0]                          sharers_hits_o,
  output logic [num_lce_p*lg_lce_assoc_lp-1:0]          sharers_ways_o,
  output logic [num_lce_p*bp_cce_coh_bits-1:0]          sharers_coh_states_o
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

  localparam logic [lg_num_lce_lp-1:0] last_lce_lp = lg_num_lce_lp'(num_lce_p - 1);

  state_e                              state_r;
  logic [lg_num_way_groups_lp-1:0]     wg_r;
  logic [tag_width_p-1:0]              tag_r;
  logic                                ram_v_r;
  logic [lg_num_lce_lp-1:0]            ram_lce_r;   // issue counter
  logic                                resp_v_r;
  logic [lg_num_lce_lp-1:0]            resp_lce_r;  // LCE index of the row on ram_data_i
  logic                                sharers_v_r;
  logic [num_lce_p-1:0]                hits_r;
  logic [num_lce_p*lg_lce_assoc_lp-1:0] ways_r;
  logic [num_lce_p*bp_cce_coh_bits-1:0] coh_r;

  logic                                row_hit;
  logic [lg_lce_assoc_lp-1:0]          row_way;
  logic [bp_cce_coh_bits-1:0]          row_coh;

  bp_cce_dir_row_cmp #(
    .lce_assoc_p (lce_assoc_p),
    .tag_width_p (tag_width_p)
  ) row_cmp (
    .row_i (ram_data_i),
    .tag_i (tag_r),
    .hit_o (row_hit),
    .way_o (row_way),
    .coh_o (row_coh)
  );

  assign rd_ready_o           = (state_r != READ);
  assign ram_v_o              = ram_v_r;
  assign ram_addr_o           = {wg_r, ram_lce_r};
  assign sharers_v_o          = sharers_v_r;
  assign sharers_hits_o       = hits_r;
  assign sharers_ways_o       = ways_r;
  assign sharers_coh_states_o = coh_r;

  // Command FSM, row issue counter, response pipe and result registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: the result vectors are ordinary flops, not a memory, so they are
    // cleared by reset along with the control state.
    if (reset_i) begin
      state_r     <= IDLE;
      wg_r        <= '0;
      tag_r       <= '0;
      ram_v_r     <= 1'b0;
      ram_lce_r   <= '0;
      resp_v_r    <= 1'b0;
      resp_lce_r  <= '0;
      sharers_v_r <= 1'b0;
      hits_r      <= '0;
      ways_r      <= '0;
      coh_r       <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every read below sees the value
      // from the start of the cycle regardless of statement order.
      resp_v_r   <= ram_v_r;
      resp_lce_r <= ram_lce_r;
      case (state_r)
        IDLE, DONE: begin
          if (rd_v_i) begin
            wg_r        <= way_group_i;
            tag_r       <= tag_i;
            ram_v_r     <= 1'b1;
            ram_lce_r   <= '0;
            sharers_v_r <= 1'b0;
            hits_r      <= '0;
            ways_r      <= '0;
            coh_r       <= '0;
            state_r     <= READ;
          end else if ((state_r == DONE) && inv_i) begin
            sharers_v_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        READ: begin
          if (ram_v_r) begin
            if (ram_lce_r == last_lce_lp) ram_v_r <= 1'b0;
            else                          ram_lce_r <= ram_lce_r + 1'b1;
          end
          if (resp_v_r) begin
            hits_r[resp_lce_r]                                   <= row_hit;
            ways_r[resp_lce_r*lg_lce_assoc_lp +: lg_lce_assoc_lp] <= row_way;
            coh_r[resp_lce_r*bp_cce_coh_bits +: bp_cce_coh_bits]  <= row_coh;
            if (resp_lce_r == last_lce_lp) begin
              sharers_v_r <= 1'b1;
              state_r     <= DONE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cce_dir_rd.sv
// Directed bench for bp_cce_dir_rd: 4 LCEs, 8 ways, 8-bit tags, 4 way-groups,
// with a 1-cycle synchronous directory RAM model.
module tb_bp_cce_dir_rd;
  import bp_cce_pkg::*;

  localparam int NL = 4, NA = 8, TW = 8, NWG = 4;
  localparam int EW = TW + 3;
  localparam int LWG = 2, LL = 2, LA = 3;

  logic clk_i = 1'b0, reset_i = 1'b1;
  logic rd_v_i = 1'b0, rd_ready_o, inv_i = 1'b0, ram_v_o, sharers_v_o;
  logic [LWG-1:0] way_group_i = '0;
  logic [TW-1:0]  tag_i = '0;
  logic [LWG+LL-1:0] ram_addr_o;
  logic [NA*EW-1:0]  ram_data_i;
  logic [NL-1:0]     sharers_hits_o;
  logic [NL*LA-1:0]  sharers_ways_o;
  logic [NL*3-1:0]   sharers_coh_states_o;

  int total = 0, bad = 0;

  bp_cce_dir_rd #(.num_lce_p(NL), .lce_assoc_p(NA), .tag_width_p(TW), .num_way_groups_p(NWG)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rd_v_i(rd_v_i), .rd_ready_o(rd_ready_o),
    .way_group_i(way_group_i), .tag_i(tag_i), .inv_i(inv_i),
    .ram_v_o(ram_v_o), .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i),
    .sharers_v_o(sharers_v_o), .sharers_hits_o(sharers_hits_o),
    .sharers_ways_o(sharers_ways_o), .sharers_coh_states_o(sharers_coh_states_o)
  );

  always #5 clk_i = ~clk_i;

  // Directory RAM model, indexed by {way_group, lce}.
  logic [NA*EW-1:0] mem [NWG*NL];
  always @(posedge clk_i) if (ram_v_o) ram_data_i <= mem[ram_addr_o];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic put(input int wg, input int lce, input int way, input logic [TW-1:0] t, input logic [2:0] c);
    mem[wg*NL+lce][way*EW +: EW] = {t, c};
  endtask

  // Issue a command at the next negedge; returns at the negedge of cycle t+1.
  task automatic start_cmd(input logic [LWG-1:0] wg, input logic [TW-1:0] t, input logic inv);
    @(negedge clk_i);
    check("ready_before_accept", rd_ready_o, 1'b1);
    rd_v_i = 1'b1; way_group_i = wg; tag_i = t; inv_i = inv;
    @(negedge clk_i);
    rd_v_i = 1'b0; inv_i = 1'b0;
  endtask

  // From cycle t+1: check issue sequence, valid timing and final vectors.
  // With poke set, inv_i and a competing rd_v_i are driven during READ.
  task automatic walk(input logic [LWG-1:0] wg, input logic poke, input logic [NL-1:0] eh,
                      input logic [NL*LA-1:0] ew, input logic [NL*3-1:0] ec);
    check("vectors_cleared_t1", sharers_hits_o, '0);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("ram_v_t%0d", i+1), ram_v_o, 1'b1);
      check($sformatf("ram_addr_t%0d", i+1), ram_addr_o, {wg, 2'(i)});
      check($sformatf("ready_low_t%0d", i+1), rd_ready_o, 1'b0);
      check($sformatf("v_low_t%0d", i+1), sharers_v_o, 1'b0);
      if (poke && i == 1) begin
        rd_v_i = 1'b1; inv_i = 1'b1; way_group_i = ~wg; tag_i = 8'hFF;
      end
      @(negedge clk_i);
      rd_v_i = 1'b0; inv_i = 1'b0;
    end
    check("ram_v_low_t5", ram_v_o, 1'b0);
    check("v_low_t5", sharers_v_o, 1'b0);
    @(negedge clk_i);
    check("v_high_t6", sharers_v_o, 1'b1);
    check("ready_t6", rd_ready_o, 1'b1);
    check("hits", sharers_hits_o, eh);
    check("ways", sharers_ways_o, ew);
    check("states", sharers_coh_states_o, ec);
  endtask

  // Expected results: way-group 1 / tag 0x2A and way-group 2 / tag 0x55.
  localparam logic [NL-1:0]    A_H = 4'b1011;
  localparam logic [NL*LA-1:0] A_W = {3'd0, 3'd0, 3'd5, 3'd3};
  localparam logic [NL*3-1:0]  A_C = {3'b110, 3'b000, 3'b001, 3'b111};
  localparam logic [NL-1:0]    B_H = 4'b0100;
  localparam logic [NL*LA-1:0] B_W = {3'd0, 3'd7, 3'd0, 3'd0};
  localparam logic [NL*3-1:0]  B_C = {3'b000, 3'b010, 3'b000, 3'b000};

  initial begin
    for (int i = 0; i < NWG*NL; i++) begin
      mem[i] = '0;
      for (int w = 0; w < NA; w++) mem[i][w*EW +: EW] = {8'h11, 3'b001};
    end
    // WG1: LCE0 ways 3 (O) and 6 (S); LCE1 way 5 (S); LCE2 way 4 invalid; LCE3 way 0 (M).
    put(1, 0, 3, 8'h2A, 3'b111); put(1, 0, 6, 8'h2A, 3'b001);
    put(1, 1, 5, 8'h2A, 3'b001);
    put(1, 2, 4, 8'h2A, 3'b000);
    put(1, 3, 0, 8'h2A, 3'b110);
    // WG2: LCE2 way 7 (E) holds 0x55; LCE0 way 0 holds 0x2A (must not match 0x55).
    put(2, 2, 7, 8'h55, 3'b010); put(2, 0, 0, 8'h2A, 3'b001);

    repeat (2) @(negedge clk_i);
    check("rst_ready", rd_ready_o, 1'b1);
    check("rst_ram_v", ram_v_o, 1'b0);
    check("rst_v", sharers_v_o, 1'b0);
    check("rst_hits", sharers_hits_o, '0);
    reset_i = 1'b0;

    // inv_i in IDLE does nothing.
    @(negedge clk_i); inv_i = 1'b1;
    @(negedge clk_i); inv_i = 1'b0;
    check("idle_inv_ready", rd_ready_o, 1'b1);
    check("idle_inv_ram_v", ram_v_o, 1'b0);

    // Basic walk: hits, lowest way, invalid state filtered.
    start_cmd(2'd1, 8'h2A, 1'b0);
    walk(2'd1, 1'b0, A_H, A_W, A_C);

    // DONE holds stable.
    repeat (3) @(negedge clk_i);
    check("done_hold_v", sharers_v_o, 1'b1);
    check("done_hold_hits", sharers_hits_o, A_H);

    // inv_i in DONE drops valid, keeps the vectors.
    inv_i = 1'b1;
    @(negedge clk_i); inv_i = 1'b0;
    check("inv_v_low", sharers_v_o, 1'b0);
    check("inv_keep_ways", sharers_ways_o, A_W);
    check("inv_ready", rd_ready_o, 1'b1);

    // Second way-group from IDLE.
    start_cmd(2'd2, 8'h55, 1'b0);
    walk(2'd2, 1'b0, B_H, B_W, B_C);

    // Accept with simultaneous inv_i in DONE: new walk starts immediately.
    start_cmd(2'd1, 8'h2A, 1'b1);
    walk(2'd1, 1'b0, A_H, A_W, A_C);

    // inv_i and rd_v_i during READ are ignored.
    start_cmd(2'd2, 8'h55, 1'b0);
    walk(2'd2, 1'b1, B_H, B_W, B_C);

    // Asynchronous reset at t+3 aborts the walk.
    start_cmd(2'd1, 8'h2A, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check("arst_ram_v", ram_v_o, 1'b0);
    check("arst_v", sharers_v_o, 1'b0);
    check("arst_ready", rd_ready_o, 1'b1);
    check("arst_hits", sharers_hits_o, '0);
    @(negedge clk_i); reset_i = 1'b0;

    start_cmd(2'd1, 8'h2A, 1'b0);
    walk(2'd1, 1'b0, A_H, A_W, A_C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
